imem_stage: RTL
===============

Name: imem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline, between EX/MEM and the writeback mux.
- Drives the data-memory request/acknowledge bus and formats stores (byte strobes, lane replication).
- Aligns and extends load data, and stalls the pipeline while memory is outstanding.
- Owns the MEM/WB pipeline register whose outputs feed the writeback select directly.

Parameters:
- WIDTH, `WIDTH (32): datapath and address width.
- RF_ADDR_W, 5: destination register index width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_imem_valid  in  1  EX/MEM slot holds a live instruction.
- i_imem_alu_out  in  WIDTH  ALU result; effective address for loads/stores.
- i_imem_store_data  in  WIDTH  rs2 value for stores.
- i_imem_funct3  in  3  access size/sign (RV32I encoding).
- i_imem_mem_read  in  1  load.
- i_imem_mem_write  in  1  store.
- i_imem_rf_wb_src_ctrl  in  3  writeback select, passed through.
- i_imem_pc_plus_4  in  WIDTH  passed through.
- i_imem_sx_data  in  WIDTH  immediate, passed through.
- i_imem_bu_next_dest_jb  in  WIDTH  jump/branch target, passed through.
- i_imem_rd  in  RF_ADDR_W  destination register.
- i_imem_reg_write  in  1  register-file write enable.
- o_dmem_req  out  1  memory request.
- o_dmem_we  out  1  write, 1 = store.
- o_dmem_addr  out  WIDTH  word-aligned address: {addr[WIDTH-1:2], 2'b00}.
- o_dmem_wdata  out  WIDTH  lane-replicated store data.
- o_dmem_be  out  4  byte strobes.
- i_dmem_ack  in  1  request complete; rdata valid on loads.
- i_dmem_rdata  in  WIDTH  raw word read.
- o_imem_stall  out  1  freeze IF..EX/MEM; upstream holds inputs stable.
- o_imem_valid, o_imem_alu_out, o_imem_r_mem, o_imem_rf_wb_src_ctrl, o_imem_pc_plus_4, o_imem_sx_data, o_imem_bu_next_dest_jb, o_imem_rd, o_imem_reg_write  out  (widths as inputs)  MEM/WB register outputs.

Behaviour:
- Reset:
  - State IDLE; o_dmem_req = 0.
  - All MEM/WB outputs = 0; o_imem_valid = 0, o_imem_reg_write = 0.
  - Reset takes precedence in every state.
  - Reset during WAIT abandons the request; memory must tolerate a dropped request.
- Access:
  - access = i_imem_valid & (mem_read | mem_write).
  - If both read and write are set, treat as a store.
- FSM states: IDLE, WAIT.
  - IDLE: o_dmem_req = access, combinational, same cycle.
    - access & ack: zero-wait; no stall.
    - access & !ack: go to WAIT.
  - WAIT: o_dmem_req = 1, holding the same addr/we/wdata/be.
    - ack: return to IDLE.
- Stall:
  - o_imem_stall = ((IDLE & access) | WAIT) & !i_dmem_ack.
  - Minimum load/store latency is one cycle into MEM/WB (zero-wait).
  - An N-wait-state access stalls for N cycles.
- MEM/WB register:
  - When !stall: loads all pass-through fields plus formatted load data.
  - When stall: loads a bubble (valid = 0, reg_write = 0, other fields don't-care but held).
  - A non-memory instruction passes through in one cycle and never touches the bus.
- Store formatting (a = addr[1:0]):
  - SB (000): be = 4'b0001 << a; wdata = {4{data[7:0]}}.
  - SH (001): be = 4'b0011 << {a[1], 1'b0}; wdata = {2{data[15:0]}}.
  - SW (010) and other codes: be = 4'b1111; wdata = data.
- Load formatting (from rdata and a, captured on ack):
  - LB: sign-extend byte at lane a.
  - LBU: zero-extend byte at lane a.
  - LH: sign-extend halfword at lane a[1].
  - LHU: zero-extend halfword at lane a[1].
  - LW and undefined codes: full word.
- Non-load instructions: o_imem_r_mem = 0.
- ack outside an access is ignored.

Optional Feature:
- Macro: IMEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned access: halfword with a[0] = 1, or word with a != 0.
  - No bus request is issued and no stall occurs.
  - MEM/WB captures valid = 1 and reg_write = 0.
  - Extra output o_imem_misaligned (1 bit, registered with MEM/WB) is 1 for that instruction; reset value 0.
- Undefined:
  - No such port.
  - Misalignment is not checked; the access uses the word address with the lane rules above, so halfword lane = a[1] and word ignores a.

Test Plan:
1. LW addr 0x100, ack same cycle, rdata 0xDEADBEEF -> req for 1 cycle, no stall; next cycle o_imem_r_mem = 0xDEADBEEF, valid = 1.
2. LB addr 0x103, ack after 2 waits, rdata 0x80FF_0000 -> stall high 2 cycles, two bubbles in MEM/WB; then r_mem = 0xFFFFFF80. Same access as LBU -> 0x00000080.
3. SH addr 0x202, data 0x1234ABCD -> be = 4'b1100, wdata = 0xABCDABCD, we = 1; reg_write passes as 0.
4. ADD (no mem), alu_out 0x55 -> no req; o_imem_alu_out = 0x55 next cycle, rf_wb_src_ctrl preserved.
5. LW issued, reset asserted in WAIT -> next cycle req = 0, state IDLE, all outputs 0; late ack ignored.
6. With IMEM_MISALIGN_TRAP_EN: LW addr 0x101 -> no req, o_imem_misaligned = 1, reg_write = 0. Without the macro: req at addr 0x100.

Source files
------------

// File: rtl/imem_stage.sv
// imem_stage: memory-access stage of the RV32I pipeline.
// Issues data-memory requests, formats store lanes and byte strobes,
// aligns/extends load data, stalls upstream while a request is outstanding
// and owns the MEM/WB pipeline register.
//
// Optional build macro: IMEM_MISALIGN_TRAP_EN
//   defined   -> misaligned halfword/word accesses are suppressed (no bus
//                request, no stall) and flagged on o_imem_misaligned.
//   undefined -> no misalignment check; lanes come from the low address bits.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no request outstanding; request follows the EX/MEM slot
// WAIT  | request issued but not yet acknowledged; hold the bus

`ifndef WIDTH
`define WIDTH 32
`endif

module imem_stage #(
  parameter int WIDTH     = `WIDTH,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_imem_valid,
  input  logic [WIDTH-1:0]     i_imem_alu_out,
  input  logic [WIDTH-1:0]     i_imem_store_data,
  input  logic [2:0]           i_imem_funct3,
  input  logic                 i_imem_mem_read,
  input  logic                 i_imem_mem_write,
  input  logic [2:0]           i_imem_rf_wb_src_ctrl,
  input  logic [WIDTH-1:0]     i_imem_pc_plus_4,
  input  logic [WIDTH-1:0]     i_imem_sx_data,
  input  logic [WIDTH-1:0]     i_imem_bu_next_dest_jb,
  input  logic [RF_ADDR_W-1:0] i_imem_rd,
  input  logic                 i_imem_reg_write,
  output logic                 o_dmem_req,
  output logic                 o_dmem_we,
  output logic [WIDTH-1:0]     o_dmem_addr,
  output logic [WIDTH-1:0]     o_dmem_wdata,
  output logic [3:0]           o_dmem_be,
  input  logic                 i_dmem_ack,
  input  logic [WIDTH-1:0]     i_dmem_rdata,
  output logic                 o_imem_stall,
  output logic                 o_imem_valid,
  output logic [WIDTH-1:0]     o_imem_alu_out,
  output logic [WIDTH-1:0]     o_imem_r_mem,
  output logic [2:0]           o_imem_rf_wb_src_ctrl,
  output logic [WIDTH-1:0]     o_imem_pc_plus_4,
  output logic [WIDTH-1:0]     o_imem_sx_data,
  output logic [WIDTH-1:0]     o_imem_bu_next_dest_jb,
  output logic [RF_ADDR_W-1:0] o_imem_rd,
`ifdef IMEM_MISALIGN_TRAP_EN
  output logic                 o_imem_misaligned,
`endif
  output logic                 o_imem_reg_write
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state, state_next;

  logic [1:0]       lane;
  logic             is_store;
  logic             is_load;
  logic             access;
  logic             misaligned;
  logic             access_bus;
  logic             req;
  logic             stall;
  logic [3:0]       be;
  logic [WIDTH-1:0] wdata;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [WIDTH-1:0] ld_data;

  assign lane     = i_imem_alu_out[1:0];
  // A slot flagged both read and write behaves as a store.
  assign is_store = i_imem_mem_write;
  assign is_load  = i_imem_mem_read & ~i_imem_mem_write;
  assign access   = i_imem_valid & (i_imem_mem_read | i_imem_mem_write);

`ifdef IMEM_MISALIGN_TRAP_EN
  // Halfword needs an even address, word needs a fully aligned one.
  always_comb begin
    misaligned = 1'b0;
    if (access) begin
      case (i_imem_funct3[1:0])
        2'b01:   misaligned = lane[0];
        2'b10:   misaligned = (lane != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  assign access_bus = access & ~misaligned;

  // State register; reset abandons any outstanding request.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state and bus handshake; reset masks the request combinationally
  // so a dropped request is never re-presented while reset is held.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    case (state)
      IDLE: begin
        req = access_bus;
        if (access_bus && !i_dmem_ack) state_next = WAIT;
      end
      WAIT: begin
        req = 1'b1;
        if (i_dmem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!i_rst_n) req = 1'b0;
  end

  assign stall = req & ~i_dmem_ack;

  // Store lane replication and byte strobes.
  always_comb begin
    be    = 4'b1111;
    wdata = i_imem_store_data;
    case (i_imem_funct3)
      3'b000: begin
        be    = 4'b0001 << lane;
        wdata = WIDTH'({4{i_imem_store_data[7:0]}});
      end
      3'b001: begin
        be    = 4'b0011 << {lane[1], 1'b0};
        wdata = WIDTH'({2{i_imem_store_data[15:0]}});
      end
      default: begin
        be    = 4'b1111;
        wdata = i_imem_store_data;
      end
    endcase
  end

  // Load lane selection and sign/zero extension.
  always_comb begin
    ld_byte = i_dmem_rdata[7:0];
    case (lane)
      2'd0: ld_byte = i_dmem_rdata[7:0];
      2'd1: ld_byte = i_dmem_rdata[15:8];
      2'd2: ld_byte = i_dmem_rdata[23:16];
      2'd3: ld_byte = i_dmem_rdata[31:24];
      default: ld_byte = i_dmem_rdata[7:0];
    endcase
    ld_half = lane[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (i_imem_funct3)
      3'b000:  ld_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(WIDTH-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(WIDTH-16){1'b0}}, ld_half};
      default: ld_data = i_dmem_rdata;
    endcase
  end

  assign o_dmem_req   = req;
  assign o_dmem_we    = req & is_store;
  assign o_dmem_addr  = {i_imem_alu_out[WIDTH-1:2], 2'b00};
  assign o_dmem_wdata = wdata;
  assign o_dmem_be    = be;
  assign o_imem_stall = stall;

  // MEM/WB register: capture the slot when not stalled, else insert a bubble.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_imem_valid           <= 1'b0;
      o_imem_alu_out         <= '0;
      o_imem_r_mem           <= '0;
      o_imem_rf_wb_src_ctrl  <= '0;
      o_imem_pc_plus_4       <= '0;
      o_imem_sx_data         <= '0;
      o_imem_bu_next_dest_jb <= '0;
      o_imem_rd              <= '0;
      o_imem_reg_write       <= 1'b0;
    end else if (!stall) begin
      o_imem_valid           <= i_imem_valid;
      o_imem_alu_out         <= i_imem_alu_out;
      o_imem_r_mem           <= (is_load && !misaligned) ? ld_data : '0;
      o_imem_rf_wb_src_ctrl  <= i_imem_rf_wb_src_ctrl;
      o_imem_pc_plus_4       <= i_imem_pc_plus_4;
      o_imem_sx_data         <= i_imem_sx_data;
      o_imem_bu_next_dest_jb <= i_imem_bu_next_dest_jb;
      o_imem_rd              <= i_imem_rd;
      o_imem_reg_write       <= i_imem_reg_write & ~misaligned;
    end else begin
      o_imem_valid     <= 1'b0;
      o_imem_reg_write <= 1'b0;
    end
  end

`ifdef IMEM_MISALIGN_TRAP_EN
  // Misalignment flag travels with the MEM/WB slot.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)    o_imem_misaligned <= 1'b0;
    else if (!stall) o_imem_misaligned <= misaligned;
    else             o_imem_misaligned <= 1'b0;
  end
`endif

endmodule
